// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Mode encodings and next-value/carry helper shared by the
//               counter_param family. Optional macro: COUNTER_PARAM_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    // Widest counter the helper supports; WIDTH must not exceed this.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        MODE_STEP = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef logic [MAX_WIDTH:0] wide_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] value;
        logic                 carry;
    } next_t;

    // Arithmetic runs one bit wider than the active width so that bit
    // `width` of the result is the carry; borrow is detected from cur == 0.
    function automatic next_t calc_next(
        input logic [MAX_WIDTH-1:0] cur,
        input logic [1:0]           mode,
        input int unsigned          width,
        input wide_t                step,
        input logic                 sat
    );
        wide_t one;
        wide_t top_bit;
        wide_t mask;
        wide_t cur_x;
        wide_t step_x;
        wide_t res;
        logic  carry;
        next_t result;

        one     = wide_t'(1);
        top_bit = one << width;
        mask    = top_bit - one;
        cur_x   = {1'b0, cur} & mask;
        step_x  = step & (top_bit | mask);
        res     = cur_x;
        carry   = 1'b0;

        case (mode)
            MODE_UP: begin
                res   = cur_x + one;
                carry = |(res & top_bit);
            end
            MODE_STEP: begin
                res   = cur_x + step_x;
                carry = |(res & top_bit);
            end
            MODE_DOWN: begin
                res   = cur_x - one;
                carry = (cur_x == '0);
            end
            default: begin
                res   = cur_x;
                carry = 1'b0;
            end
        endcase

        if (sat && carry) begin
            res = (mode == MODE_DOWN) ? '0 : mask;
        end

        result.value = res[MAX_WIDTH-1:0] & mask[MAX_WIDTH-1:0];
        result.carry = carry;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_param_if.sv
// ============================================================================
// Module      : counter_param_if
// Description : Control/data bundle of one counter_param stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic             rci;
    logic [1:0]       mode;
    logic [WIDTH-1:0] D;
    logic             load;
    logic             rco;
    logic [WIDTH-1:0] Q;

    modport master (
        output enable, rci, mode, D,
        input  load, rco, Q
    );

    modport slave (
        input  enable, rci, mode, D,
        output load, rco, Q
    );
endinterface

`default_nettype wire

// File: rtl/counter_param_next.sv
// ============================================================================
// Module      : counter_param_next
// Description : Combinational next-count and carry/borrow calculator.
//               Saturating arithmetic when COUNTER_PARAM_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_param_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  wire logic [WIDTH-1:0] i_cur,
    input  wire logic [1:0]       i_mode,
    output logic      [WIDTH-1:0] o_next,
    output logic                  o_carry
);

    localparam wide_t C_STEP_X = wide_t'(STEP);

    next_t w_res;
    logic  w_sat;

`ifdef COUNTER_PARAM_SAT_EN
    assign w_sat = 1'b1;
`else
    assign w_sat = 1'b0;
`endif

    always_comb begin
        w_res = calc_next(MAX_WIDTH'(i_cur), i_mode, WIDTH, C_STEP_X, w_sat);
    end

    assign o_next  = w_res.value[WIDTH-1:0];
    assign o_carry = w_res.carry;

    // Helper result is always MAX_WIDTH wide; the upper bits are zero by construction.
    generate
        if (WIDTH < MAX_WIDTH) begin : g_upper_unused
            logic w_unused_upper;
            assign w_unused_upper = ^w_res.value[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/counter_param.sv
// ============================================================================
// Module      : counter_param
// Description : Cascadable up/down/step/load counter with registered Q, rco
//               and load. Optional macro: COUNTER_PARAM_SAT_EN (saturation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    counter_param_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rco_q;
    logic             rco_d;
    logic             load_q;
    logic             load_d;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;

    counter_param_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .i_cur   (count_q),
        .i_mode  (bus.mode),
        .o_next  (w_next),
        .o_carry (w_carry)
    );

    // Load ignores rci; counting needs both enable and rci.
    always_comb begin
        count_d = count_q;
        rco_d   = 1'b0;
        load_d  = 1'b0;
        if (bus.enable) begin
            if (bus.mode == MODE_LOAD) begin
                count_d = bus.D;
                load_d  = 1'b1;
            end else if (bus.rci) begin
                count_d = w_next;
                rco_d   = w_carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            rco_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            rco_q   <= rco_d;
            load_q  <= load_d;
        end
    end

    assign bus.Q    = count_q;
    assign bus.rco  = rco_q;
    assign bus.load = load_q;

endmodule

`default_nettype wire
